unpool_2x2_stream: RTL



---
 rtl/unpool_2x2_stream_pkg.sv | 14 +
 rtl/unpool_line_buf.sv | 35 +++
 rtl/unpool_2x2_stream.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/unpool_2x2_stream_pkg.sv
// Shared defaults and state encoding for the 2x2 nearest-neighbour unpooling stage.
package unpool_2x2_stream_pkg;

  localparam int PW_DEF  = 15;
  localparam int PH_DEF  = 15;
  localparam int PWB_DEF = $clog2(PW_DEF);
  localparam int PHB_DEF = $clog2(PH_DEF);

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } state_t;

endpackage

// File: rtl/unpool_line_buf.sv
// One row of pooled pixels, written during the first output row and replayed during the second.
module unpool_line_buf #(
  parameter int PW  = 15,
  parameter int PWB = 4
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           wr_en,
  input  logic [PWB-1:0] wr_addr,
  input  logic           wr_data,
  input  logic [PWB-1:0] rd_addr,
  output logic           rd_data
);

  logic [PW-1:0] mem;

  always_ff @(posedge clk) begin
    if (clr) begin
      mem <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < PW; i++) begin
        if (wr_addr == PWB'(i)) mem[i] <= wr_data;
      end
    end
  end

  // Compare-based decode keeps out-of-range addresses harmless (they read 0).
  always_comb begin
    rd_data = 1'b0;
    for (int i = 0; i < PW; i++) begin
      if (rd_addr == PWB'(i)) rd_data = mem[i];
    end
  end

endmodule

// File: rtl/unpool_2x2_stream.sv
// 2x nearest-neighbour upsampler for 1-bit pixel streams with valid/ready on both sides.
module unpool_2x2_stream
  import unpool_2x2_stream_pkg::*;
#(
  parameter int PW  = PW_DEF,
  parameter int PWB = PWB_DEF,
  parameter int PH  = PH_DEF,
  parameter int PHB = PHB_DEF
) (
  input  logic iCLK,
  input  logic iRSTn,
  input  logic iCLR,
  input  logic iEN,
  input  logic iDATA,
  output logic oREADY,
  output logic oVALID,
  output logic oDATA,
  input  logic iREADY,
  output logic oEOL,
  output logic oEOF
);

  state_t         state, state_nx;
  logic [PWB-1:0] col, col_nx;
  logic [PHB-1:0] row, row_nx;
  logic           phase, phase_nx;
  logic           valid_q, valid_nx;
  logic           data_q, data_nx;
  logic           eol_q, eol_nx;
  logic           eof_q, eof_nx;

  logic           clear;
  logic           last_col;
  logic           last_row;
  logic           xfer;
  logic           accept;
  logic [PWB-1:0] wr_addr;
  logic [PWB-1:0] rd_addr;
  logic           rd_data;

  assign clear    = !iRSTn || iCLR;
  assign last_col = (col == PWB'(PW - 1));
  assign last_row = (row == PHB'(PH - 1));
  assign xfer     = valid_q && iREADY;

  // In EVEN, valid_q doubles as the hold-register "full" flag.
  assign oREADY = !clear && (state == EVEN) &&
                  (!valid_q || (phase && iREADY && !last_col));
  assign accept = iEN && oREADY;

  // A pixel taken while the hold is still draining belongs to the next column.
  assign wr_addr = valid_q ? col + PWB'(1) : col;
  assign rd_addr = (state == ODD && !last_col) ? col + PWB'(1) : '0;

  unpool_line_buf #(
    .PW  (PW),
    .PWB (PWB)
  ) u_line_buf (
    .clk     (iCLK),
    .clr     (clear),
    .wr_en   (accept),
    .wr_addr (wr_addr),
    .wr_data (iDATA),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge iCLK) begin
    if (clear) begin
      state   <= EVEN;
      col     <= '0;
      row     <= '0;
      phase   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      col     <= col_nx;
      row     <= row_nx;
      phase   <= phase_nx;
      valid_q <= valid_nx;
      data_q  <= data_nx;
      eol_q   <= eol_nx;
      eof_q   <= eof_nx;
    end
  end

  always_comb begin
    state_nx = state;
    col_nx   = col;
    row_nx   = row;
    phase_nx = phase;
    valid_nx = valid_q;
    data_nx  = data_q;
    eol_nx   = eol_q;
    eof_nx   = eof_q;

    case (state)
      EVEN: begin
        if (!valid_q) begin
          if (accept) begin
            valid_nx = 1'b1;
            data_nx  = iDATA;
            phase_nx = 1'b0;
            eol_nx   = 1'b0;
            eof_nx   = 1'b0;
          end
        end else if (xfer) begin
          if (!phase) begin
            phase_nx = 1'b1;
            eol_nx   = last_col;
          end else begin
            phase_nx = 1'b0;
            eol_nx   = 1'b0;
            if (last_col) begin
              // Start replaying the row straight away from column 0.
              state_nx = ODD;
              col_nx   = '0;
              valid_nx = 1'b1;
              data_nx  = rd_data;
            end else begin
              col_nx   = col + PWB'(1);
              valid_nx = accept;
              if (accept) data_nx = iDATA;
            end
          end
        end
      end

      ODD: begin
        if (xfer) begin
          if (!phase) begin
            phase_nx = 1'b1;
            eol_nx   = last_col;
            eof_nx   = last_col && last_row;
          end else begin
            phase_nx = 1'b0;
            eol_nx   = 1'b0;
            eof_nx   = 1'b0;
            if (last_col) begin
              state_nx = EVEN;
              col_nx   = '0;
              row_nx   = last_row ? '0 : row + PHB'(1);
              valid_nx = 1'b0;
            end else begin
              col_nx  = col + PWB'(1);
              data_nx = rd_data;
            end
          end
        end
      end

      default: state_nx = EVEN;
    endcase
  end

  assign oVALID = valid_q;
  assign oDATA  = data_q;
  assign oEOL   = eol_q;
  assign oEOF   = eof_q;

endmodule
